serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands a, b, cin are valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port a  input  WIDTH  addend A.
REQ-007 SHALL have port b  input  WIDTH  addend B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  sum and cout are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port sum  output  WIDTH  result bits.
REQ-012 SHALL have port cout  output  1  carry-out of the MSB.

Function
REQ-013 SHALL compute {cout,sum} = a + b + cin (unsigned, WIDTH+1 bits) using one 1-bit full-adder cell, reused once per bit, LSB first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE (registered state decode, no combinational path from in_valid).
REQ-016 IDLE -> RUN on the edge where in_valid && in_ready: latch a and b into shift registers, carry register <= cin, bit counter <= 0.
REQ-017 In RUN, each cycle SHALL: add operand LSBs and the carry register, shift the sum bit into the result register from the MSB end, update the carry register, shift operands right, increment the counter.
REQ-018 RUN -> DONE on the edge processing the bit where counter == WIDTH-1; WIDTH=1 spends exactly one cycle in RUN.
REQ-019 out_valid SHALL be 1 exactly when the state is DONE; it rises WIDTH cycles after the accepting edge.
REQ-020 DONE -> IDLE on the edge where out_valid && out_ready; minimum issue interval is WIDTH+2 cycles.
REQ-021 sum and cout SHALL hold stable throughout DONE, including while out_ready is 0.
REQ-022 sum and cout SHALL retain their last values in IDLE and RUN; they are only meaningful while out_valid = 1.
REQ-023 in_valid, a, b and cin SHALL be ignored outside IDLE; operand changes after acceptance do not affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE and clear shift registers, carry, counter, sum and cout to 0, regardless of clock.
REQ-026 During reset, in_ready = 0. After release, in_ready = 1 and out_valid = 0.
REQ-027 Reset during RUN or DONE SHALL discard the operation with no output handshake.

Configuration
REQ-028 With macro SERIAL_ADD_OVF_EN defined, the block SHALL add port ovf (output, 1 bit): two's-complement overflow = carry into MSB XOR cout, captured on the final RUN cycle, held in DONE, reset to 0.
REQ-029 Without SERIAL_ADD_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0; out_valid rises exactly 8 cycles after the accept edge.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (macro defined); build without the macro compiles with no ovf port.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a, b -> sum/cout unchanged, in_ready=0; the next operation starts only after out_ready=1.
REQ-034 Assert rst_n=0 mid-RUN (after 3 bits) -> outputs 0 and state IDLE immediately; after release, in_ready=1 and a new operation 0x01+0x01 gives 0x02.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell reused LSB first, valid/ready on both sides
// Optional ovf output (two's-complement overflow) when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
    logic [CW-1:0] cnt;
    logic carry, fa_s, fa_c, last;
    assign in_ready  = rst_n && state == IDLE;
    assign out_valid = state == DONE;
    assign fa_s   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last   = state == RUN && cnt == CW'(WIDTH - 1);
    assign res_nx = (res_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    always_comb begin
        state_n = (state == IDLE && in_valid) ? RUN :
                  last                        ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nx;
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
            // Outputs load only on the final bit so they stay put while RUN shifts
            if (last) begin
                sum  <= res_nx;
                cout <= fa_c;
            end
        end
    end
`ifdef SERIAL_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf <= 1'b0;
        else if (last) ovf <= carry ^ fa_c;
    end
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized + directed self-checking bench against an arithmetic reference
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, cout;
    logic [W-1:0] a = '0, b = '0, sum;
    logic [W-1:0] last_sum = '0;
    logic last_cout = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf;
`endif
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int hold);
        logic [W:0] ref_v;
        logic exp_ovf;
        int n;
        ref_v   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        exp_ovf = (ta[W-1] == tb[W-1]) && (ref_v[W-1] != ta[W-1]);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before", 64'(in_ready), 64'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            chk("busy_not_ready", 64'(in_ready), 64'd0);
            chk("sum_retained", 64'(sum), 64'(last_sum));
            chk("cout_retained", 64'(cout), 64'(last_cout));
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'(W));
        chk("sum", 64'(sum), 64'(ref_v[W-1:0]));
        chk("cout", 64'(cout), 64'(ref_v[W]));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            chk("hold_sum", 64'(sum), 64'(ref_v[W-1:0]));
            chk("hold_cout", 64'(cout), 64'(ref_v[W]));
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_back", 64'(in_ready), 64'd1);
        last_sum  = ref_v[W-1:0];
        last_cout = ref_v[W];
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        #14 rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        do_op(8'h5A, 8'h33, 1'b0, 0);
        chk("dir_5a33_sum", 64'(sum), 64'h8D);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        chk("dir_ff01_cout", 64'(cout), 64'd1);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        chk("dir_ffff1_sum", 64'(sum), 64'hFF);
        do_op(8'h7F, 8'h01, 1'b0, 5);
        chk("dir_7f01_sum", 64'(sum), 64'h80);

        for (int k = 0; k < 30; k++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        a = 8'hAB; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_ready", 64'(in_ready), 64'd0);
        chk("midrun_rst_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_sum", 64'(sum), 64'd0);
        chk("midrun_rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerelease_ready", 64'(in_ready), 64'd1);
        chk("rerelease_valid", 64'(out_valid), 64'd0);
        last_sum = '0;
        last_cout = 1'b0;
        do_op(8'h01, 8'h01, 1'b0, 0);
        chk("after_rst_sum", 64'(sum), 64'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
